alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Sequencer/arbiter that shares the single-cycle ALU between two requesters, e.g. the main datapath and a coprocessor/debug port.
- Accepts one operation at a time from either requester with a req/ack handshake.
- Drives the ALU's operand and control inputs from registered copies, holds them for a configurable number of cycles on multiply, captures data/zero, and returns them with a one-cycle ack.
- Round-robin arbitration by default.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- MUL_LAT, 4, cycles the ALU inputs are held for multiply (ALUCtrl 3'b011); legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req0_i  input  1  requester 0 request; held high with operands stable until ack0_o.
- op0_i  input  3  requester 0 ALUCtrl code.
- a0_i  input  WIDTH  requester 0 operand 1.
- b0_i  input  WIDTH  requester 0 operand 2.
- req1_i  input  1  requester 1 request.
- op1_i  input  3  requester 1 ALUCtrl code.
- a1_i  input  WIDTH  requester 1 operand 1.
- b1_i  input  WIDTH  requester 1 operand 2.
- ack0_o  output  1  one-cycle pulse; result_o/zero_o valid for requester 0.
- ack1_o  output  1  one-cycle pulse for requester 1.
- result_o  output  WIDTH  registered ALU result, shared by both requesters.
- zero_o  output  1  registered ALU Zero flag.
- busy_o  output  1  high in EXEC and RESP.
- grant_o  output  1  index of current or last winner.
- alu_data1_o  output  WIDTH  to ALU data1_i.
- alu_data2_o  output  WIDTH  to ALU data2_i.
- alu_ctrl_o  output  3  to ALU ALUCtrl_i.
- alu_data_i  input  WIDTH  from ALU data_o.
- alu_zero_i  input  1  from ALU Zero_o.

Behaviour:
- Reset (rst_i low, asynchronous):
  - State IDLE.
  - All outputs 0; alu_ctrl_o = 3'b000.
  - RR pointer = 0, so requester 0 has priority first.
  - Cycle counter = 0.
- Legal ops: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SUB, 011 MUL.
- States:
  - IDLE, no request: stay.
  - IDLE, any req high: pick winner; latch op/a/b into internal regs; set grant_o.
    - Counter = MUL_LAT-1 for MUL, else 0.
    - Go EXEC.
    - Winner selection: if both requests are high, the RR pointer wins; otherwise the sole requester wins.
  - EXEC:
    - alu_* outputs driven from the latched regs and constant throughout EXEC.
    - counter != 0: decrement and stay.
    - counter == 0: capture alu_data_i into result_o and alu_zero_i into zero_o; go RESP.
  - RESP:
    - ack[grant_o] high for exactly this cycle.
    - RR pointer = ~grant_o.
    - Go IDLE.
- Illegal op (100, 101):
  - Not issued; alu_ctrl_o keeps its previous value.
  - EXEC is skipped: IDLE -> RESP directly.
  - result_o = 0, zero_o = 1.
- Latency, from the IDLE cycle in which req is sampled to the ack cycle:
  - 2 cycles for non-MUL ops.
  - MUL_LAT+1 cycles for MUL.
  - 1 cycle for illegal ops.
- result_o and zero_o hold their value until the next capture.
- alu_* outputs hold their last value in IDLE; they are not zeroed.
- A requester must drop req in the cycle after its ack. If req is still high when the block re-enters IDLE, it is a new request.
- Back-to-back contention (both requests held): requests alternate 0,1,0,1.
- Request deasserted before ack (protocol violation): the operation still completes on the latched operands and the ack is still issued.
- Reset mid-operation: aborts, no ack issued. Pending requests are re-arbitrated from pointer 0 after release.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined:
  - Requester 0 always wins contention.
  - RR pointer is not implemented.
- ALU_ARB_FIXED_PRIO_EN undefined: round-robin as above.

Test Plan:
- Single request: after reset, req0 with op=010, a=5, b=7 -> alu_ctrl_o=010 in EXEC; ack0_o pulses 2 cycles after req is sampled; result_o=12, zero_o=0.
- Multiply stall: req1 with op=011, a=6, b=7, MUL_LAT=4 -> alu_* outputs stable for 4 EXEC cycles; ack1_o at cycle 5; result_o=42.
- Contention:
  - Both reqs held, ops 110 (9-9) and 001 (0x0F|0xF0) -> order req0, req1, req0; zero_o=1 on SUB, result 0xFF on OR.
  - Same stimulus with ALU_ARB_FIXED_PRIO_EN defined -> req0 always wins.
- Illegal op: req0 with op=100 -> ack0_o one cycle after sampling; result_o=0, zero_o=1; alu_ctrl_o unchanged.
- Reset mid-MUL: assert rst_i low during the 2nd EXEC cycle -> all outputs 0 immediately, no ack. After release with req1 still high, the op re-executes and ack1_o arrives.
- Zero flag passthrough: SUB a=3, b=3 -> result_o=0, zero_o=1; AND 0xF0 & 0x0F -> zero_o=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester sequencer for a shared single-cycle ALU: round-robin arbitration,
// registered ALU drive, multiply hold, one-cycle ack. Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic [2:0]       op0_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic             req1_i,
  input  logic [2:0]       op1_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic             ack0_o,
  output logic             ack1_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             grant_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic             alu_zero_i,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a requester raises req with op/a/b stable; the op is latched in the
  // IDLE cycle it is sampled, and ackN_o pulses exactly one cycle with result_o/zero_o
  // valid. The requester drops req in the cycle after its ack.

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [3:0] MUL_HOLD = 4'(MUL_LAT - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [1:0]       ack_q;
  logic             busy_q;
  logic             grant_q;
  logic             zero_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] data1_q;
  logic [WIDTH-1:0] data2_q;
  logic [2:0]       ctrl_q;

  logic             any_req;
  logic             win;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_legal;

  assign any_req = req0_i | req1_i;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win = ~req0_i;
`else
  logic rr_ptr_q;
  assign win = (req0_i & req1_i) ? rr_ptr_q : ~req0_i;
`endif

  always_comb begin
    sel_op = op0_i;
    sel_a  = a0_i;
    sel_b  = b0_i;
    if (win) begin
      sel_op = op1_i;
      sel_a  = a1_i;
      sel_b  = b1_i;
    end
  end

  // Codes 100 and 101 are not ALU operations and bypass EXEC entirely.
  assign sel_legal = (sel_op[2:1] != 2'b10);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      ack_q    <= 2'b00;
      busy_q   <= 1'b0;
      grant_q  <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      ctrl_q   <= 3'b000;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q <= win;
            busy_q  <= 1'b1;
            if (sel_legal) begin
              ctrl_q  <= sel_op;
              data1_q <= sel_a;
              data2_q <= sel_b;
              cnt_q   <= (sel_op == OP_MUL) ? MUL_HOLD : 4'd0;
              state_q <= ST_EXEC;
            end else begin
              result_q <= '0;
              zero_q   <= 1'b1;
              ack_q    <= win ? 2'b10 : 2'b01;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            result_q <= alu_data_i;
            zero_q   <= alu_zero_i;
            ack_q    <= grant_q ? 2'b10 : 2'b01;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          rr_ptr_q <= ~grant_q;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack0_o      = ack_q[0];
  assign ack1_o      = ack_q[1];
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign busy_o      = busy_q;
  assign grant_o     = grant_q;
  assign alu_data1_o = data1_q;
  assign alu_data2_o = data2_q;
  assign alu_ctrl_o  = ctrl_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus random two-requester traffic
// against a transaction-level reference (arbitration, latency, results).
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int ML = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req0_i, req1_i;
  logic [2:0]   op0_i, op1_i;
  logic [W-1:0] a0_i, b0_i, a1_i, b1_i;
  logic         ack0_o, ack1_o, zero_o, busy_o, grant_o;
  logic [W-1:0] result_o, alu_data1_o, alu_data2_o, alu_data_i;
  logic [2:0]   alu_ctrl_o;
  logic         alu_zero_i;
  logic [1:0]   dbg_state_o;

  alu_arbiter #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .op0_i(op0_i), .a0_i(a0_i), .b0_i(b0_i),
    .req1_i(req1_i), .op1_i(op1_i), .a1_i(a1_i), .b1_i(b1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .result_o(result_o), .zero_o(zero_o),
    .busy_o(busy_o), .grant_o(grant_o),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i), .dbg_state_o(dbg_state_o)
  );

  // clock / cycle count
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:         return a & b;
      3'b001:         return a | b;
      3'b010:         return a + b;
      3'b110, 3'b111: return a - b;
      3'b011:         return a * b;
      default:        return '0;
    endcase
  endfunction

  // behavioural single-cycle ALU
  always_comb begin
    alu_data_i = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);
    alu_zero_i = (alu_data_i == '0);
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: one transaction at a time
  bit           busy_m = 0;
  int           e_m = 0, lat_m = 0;
  bit           who_m = 0, legal_m = 0, ptr_m = 0, grant_m = 0, zero_m = 0;
  logic [2:0]   op_m, ctrl_m = 3'b000;
  logic [W-1:0] a_m, b_m, d1_m = '0, d2_m = '0, res_m = '0;

  function automatic bit inflight(input bit k);
    return busy_m && (who_m == k) && (cyc <= e_m + lat_m - 1);
  endfunction

  task automatic model_reset();
    busy_m = 0; ptr_m = 0; grant_m = 0; zero_m = 0;
    ctrl_m = 3'b000; d1_m = '0; d2_m = '0; res_m = '0;
    exp_q.delete();
  endtask

  // called just before a rising edge with the inputs that edge will sample
  task automatic model_sample();
    bit both;
    if (rst_i && !(busy_m && cyc < e_m + lat_m) && (req0_i || req1_i)) begin
      both = req0_i && req1_i;
`ifdef ALU_ARB_FIXED_PRIO_EN
      who_m = !req0_i;
`else
      who_m = both ? ptr_m : !req0_i;
`endif
      op_m    = who_m ? op1_i : op0_i;
      a_m     = who_m ? a1_i  : a0_i;
      b_m     = who_m ? b1_i  : b0_i;
      legal_m = !(op_m == 3'b100 || op_m == 3'b101);
      lat_m   = !legal_m ? 1 : ((op_m == 3'b011) ? ML + 1 : 2);
      e_m     = cyc + 1;
      busy_m  = 1;
      exp_q.push_back(legal_m ? alu_fn(op_m, a_m, b_m) : '0);
    end
  endtask

  task automatic check_cycle();
    bit txn, ack_now;
    txn     = busy_m && cyc >= e_m && cyc <= e_m + lat_m - 1;
    ack_now = busy_m && cyc == e_m + lat_m - 1;
    if (busy_m && cyc == e_m) begin
      grant_m = who_m;
      if (legal_m) begin
        ctrl_m = op_m; d1_m = a_m; d2_m = b_m;
      end
    end
    if (ack_now) begin
      check("sb_nonempty", W'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) res_m = exp_q.pop_front();
      zero_m = (res_m == '0);
      ptr_m  = ~who_m;
    end
    check("ack0", ack0_o, ack_now && !who_m);
    check("ack1", ack1_o, ack_now && who_m);
    check("busy", busy_o, txn);
    check("grant", grant_o, grant_m);
    check("result", result_o, res_m);
    check("zero", zero_o, zero_m);
    check("alu_ctrl", alu_ctrl_o, ctrl_m);
    check("alu_d1", alu_data1_o, d1_m);
    check("alu_d2", alu_data2_o, d2_m);
  endtask

  // driver tasks
  task automatic step();
    model_sample();
    @(posedge clk_i);
    @(negedge clk_i);
    check_cycle();
    if (ack0_o) req0_i = 1'b0;
    if (ack1_o) req1_i = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ack0", ack0_o, 0);
    check("rst_ack1", ack1_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_result", result_o, 0);
    check("rst_zero", zero_o, 0);
    check("rst_ctrl", alu_ctrl_o, 0);
    check("rst_d1", alu_data1_o, 0);
    check("rst_d2", alu_data2_o, 0);
    check("rst_state", dbg_state_o, 0);
  endtask

  // asserts reset asynchronously at a falling edge, releases one cycle later
  task automatic do_reset();
    rst_i = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs();
    rst_i = 1'b1;
  endtask

  task automatic run_op(input bit k, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int n);
    if (k) begin op1_i = op; a1_i = a; b1_i = b; req1_i = 1'b1; end
    else   begin op0_i = op; a0_i = a; b0_i = b; req0_i = 1'b1; end
    n = 0;
    while ((k ? req1_i : req0_i) && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) begin
      check("ack_timeout", 0, 1);
      req0_i = 1'b0; req1_i = 1'b0;
    end
  endtask

  initial begin
    int n;
    int acks;
    bit order[3];
    bit exp_order[3];
    rst_i = 1'b0;
    req0_i = 0; req1_i = 0; op0_i = 0; op1_i = 0;
    a0_i = 0; b0_i = 0; a1_i = 0; b1_i = 0;
    @(negedge clk_i);
    do_reset();
    repeat (2) step();

    // single ADD from requester 0
    run_op(0, 3'b010, 5, 7, n);
    check("add_lat", n, 2);
    check("add_result", result_o, 12);
    check("add_zero", zero_o, 0);
    check("add_ctrl", alu_ctrl_o, 3'b010);
    step();

    // multiply stall from requester 1
    run_op(1, 3'b011, 6, 7, n);
    check("mul_lat", n, ML + 1);
    check("mul_result", result_o, 42);
    step();

    // contention: both held, re-raised the cycle after each ack
    op0_i = 3'b110; a0_i = 9;    b0_i = 9;
    op1_i = 3'b001; a1_i = 'h0F; b1_i = 'hF0;
    req0_i = 1; req1_i = 1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 3; i++) begin
      step();
      if (ack0_o || ack1_o) begin
        order[acks] = ack1_o;
        acks++;
        check("cont_result", result_o, ack1_o ? 'hFF : 0);
        check("cont_zero", zero_o, ack1_o ? 0 : 1);
      end else begin
        if (!req0_i) req0_i = 1;
        if (!req1_i) req1_i = 1;
      end
    end
    check("cont_acks", acks, 3);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0;
`else
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;
`endif
    for (int i = 0; i < 3; i++) check("cont_order", order[i], exp_order[i]);
    req0_i = 0; req1_i = 0;
    repeat (8) step();

    // illegal op: no issue, 1-cycle ack
    run_op(0, 3'b100, 'h1234, 'h55, n);
    check("ill_lat", n, 1);
    check("ill_result", result_o, 0);
    check("ill_zero", zero_o, 1);
    check("ill_ctrl", alu_ctrl_o, 3'b110);
    step();

    // zero flag passthrough
    run_op(1, 3'b110, 3, 3, n);
    check("sub_result", result_o, 0);
    check("sub_zero", zero_o, 1);
    step();
    run_op(0, 3'b000, 'hF0, 'h0F, n);
    check("and_zero", zero_o, 1);
    step();

    // reset during the second EXEC cycle of a multiply
    op1_i = 3'b011; a1_i = 6; b1_i = 7; req1_i = 1;
    step();
    step();
    check("mid_busy", busy_o, 1);
    do_reset();
    n = 0;
    while (req1_i && n < 30) begin
      step();
      n++;
    end
    check("rst_reexec_lat", n, ML + 1);
    check("rst_reexec_result", result_o, 42);
    step();

    // random traffic, including occasional early req drop
    for (int i = 0; i < 600; i++) begin
      if (!req0_i && !ack0_o && !inflight(0) && $urandom_range(0, 2) == 0) begin
        op0_i = 3'($urandom_range(0, 7)); a0_i = $urandom;
        b0_i = ($urandom_range(0, 3) == 0) ? a0_i : $urandom;
        req0_i = 1;
      end else if (req0_i && inflight(0) && $urandom_range(0, 19) == 0) begin
        req0_i = 0;
      end
      if (!req1_i && !ack1_o && !inflight(1) && $urandom_range(0, 2) == 0) begin
        op1_i = 3'($urandom_range(0, 7)); a1_i = $urandom;
        b1_i = ($urandom_range(0, 3) == 0) ? a1_i : $urandom;
        req1_i = 1;
      end else if (req1_i && inflight(1) && $urandom_range(0, 19) == 0) begin
        req1_i = 0;
      end
      step();
    end
    req0_i = 0; req1_i = 0;
    repeat (10) step();
    check("sb_drained", W'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
